// File: rtl/cnt_cmd_pkg.sv
// Shared opcodes and run-state encoding for the seconds-counter
// command path.
package cnt_cmd_pkg;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_START = 3'b001;
  localparam logic [2:0] OP_PAUSE = 3'b010;
  localparam logic [2:0] OP_STOP  = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    BAD    = 2'd3
  } run_state_e;

  typedef struct packed {
    logic stop;
    logic pause;
    logic start;
  } press_t;

  // Keep only the highest-priority press: stop, then pause, then start.
  function automatic press_t press_prio(press_t p);
    press_t r;
    r = '0;
    if (p.stop) r.stop = 1'b1;
    else if (p.pause) r.pause = 1'b1;
    else if (p.start) r.start = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF sync -> stable-count debouncer -> press pulse.
// Pulse is high for one cycle after the debounced level rises.
module btn_debounce
  import cnt_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic          lvl_q, lvl_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn};
    lvl_d  = lvl_q;
    prev_d = lvl_q;
    cnt_d  = '0;
    // Any matching sample clears the run of mismatches.
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CMAX) lvl_d = ~lvl_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign press = lvl_q & ~prev_q;

endmodule

// File: rtl/cnt_cmd_gen.sv
// Button-driven command initiator for the seconds counter.
// Define CMD_TOGGLE_EN to make btn_start pause a running counter.
module cnt_cmd_gen
  import cnt_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_stop,
  output logic [2:0] opcode,
  output logic       valid,
  output logic [1:0] state
);

  press_t raw_ev, ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .rst(rst), .btn(btn_start), .press(raw_ev.start)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .rst(rst), .btn(btn_pause), .press(raw_ev.pause)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .clk(clk), .rst(rst), .btn(btn_stop), .press(raw_ev.stop)
  );

  assign ev = press_prio(raw_ev);

  run_state_e state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    opcode_d = OP_NONE;
    case (state_q)
      IDLE: begin
        if (ev.stop) begin
          opcode_d = OP_STOP;
        end else if (ev.start) begin
          state_d  = RUN;
          opcode_d = OP_START;
        end
      end
      RUN: begin
        if (ev.stop) begin
          state_d  = IDLE;
          opcode_d = OP_STOP;
        end else if (ev.pause) begin
          state_d  = PAUSED;
          opcode_d = OP_PAUSE;
`ifdef CMD_TOGGLE_EN
        end else if (ev.start) begin
          state_d  = PAUSED;
          opcode_d = OP_PAUSE;
`endif
        end
      end
      PAUSED: begin
        if (ev.stop) begin
          state_d  = IDLE;
          opcode_d = OP_STOP;
        end else if (ev.start) begin
          state_d  = RUN;
          opcode_d = OP_START;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (opcode_d != OP_NONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      opcode_q <= OP_NONE;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      valid_q  <= valid_d;
    end
  end

  assign opcode = opcode_q;
  assign valid  = valid_q;
  assign state  = state_q;

endmodule

// File: doc/cnt_cmd_gen.md
# cnt_cmd_gen

Command initiator for the seconds counter: synchronises and debounces three raw push-buttons (start, pause, stop), tracks counter run state, and issues one-hot opcodes with a single-cycle `valid` strobe. Sits between the board buttons and the counter's `opcode`/`valid` inputs, all in the 50 MHz `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz); legal range ≥ 2.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: reset, asynchronous, active-low.
- `btn_start` input 1: raw start button, active-high, asynchronous to `clk`.
- `btn_pause` input 1: raw pause button, active-high, asynchronous.
- `btn_stop` input 1: raw stop button, active-high, asynchronous.
- `opcode` output 3: one-hot command, START=3'b001, PAUSE=3'b010, STOP=3'b100; 3'b000 when `valid` low.
- `valid` output 1: one-cycle strobe qualifying `opcode`.
- `state` output 2: current run state, IDLE=2'd0, RUN=2'd1, PAUSED=2'd2.

## Operation
- Per button: 2-FF synchroniser, then debouncer. Debouncer holds a debounced level (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES+1). Synchronised sample ≠ debounced level: counter increments; equal: counter clears. When counter reaches DEBOUNCE_CYCLES, debounced level flips, counter clears.
- Press event: rising edge of debounced level (registered previous level). Release generates nothing.
- Simultaneous press events in one cycle: priority STOP > PAUSE > START; lower-priority events that cycle are dropped, not queued.
- FSM (state register, reset IDLE):
  - IDLE: start → RUN, issue START; stop → stay IDLE, issue STOP; pause → ignored.
  - RUN: pause → PAUSED, issue PAUSE; stop → IDLE, issue STOP; start → ignored (see Configuration).
  - PAUSED: start → RUN, issue START; stop → IDLE, issue STOP; pause → ignored.
  - Encoding 2'd3 unreachable; if entered, next state IDLE, no command.
- Ignored events produce no `valid`.
- `opcode` and `valid` are registered; at most one command per cycle.

## Timing
- Reset values: `opcode`=3'b000, `valid`=0, `state`=IDLE; synchronisers, debounced levels, edge registers, counters all 0.
- Latency: raw button high first sampled at edge 0 and held → `valid` high after edge DEBOUNCE_CYCLES+3, for exactly one cycle; `state` updates on the same edge as `valid` rises.
- Any bounce (one-cycle mismatch return) before the count completes restarts the count from 0.
- Button held continuously: exactly one command; a new command needs release (debounced low) then press.
- Reset asserted mid-count or mid-strobe: all outputs return to reset values immediately; a button held through reset release produces a press event after full debounce.

## Configuration
- `CMD_TOGGLE_EN` defined: `btn_start` in RUN issues PAUSE and moves to PAUSED (start acts as start/pause toggle); `btn_pause` behaviour unchanged.
- Not defined: `btn_start` in RUN is ignored.

## Structure
- Shared package `cnt_cmd_pkg`: opcode localparams OP_START/OP_PAUSE/OP_STOP (3'b001/3'b010/3'b100, shared with the counter) and run-state encoding IDLE/RUN/PAUSED.
- Sub-module `btn_debounce` (synchroniser + debouncer + edge detect, parameter DEBOUNCE_CYCLES, output `press` pulse), instantiated three times; FSM and output register in `cnt_cmd_gen`.

## Test plan
All with DEBOUNCE_CYCLES=4.
- Reset, idle buttons for 20 cycles → `valid`=0, `opcode`=3'b000, `state`=IDLE throughout.
- `btn_start` high from edge 0, held 20 cycles → `valid`=1 with `opcode`=3'b001 only after edge 7; `state`=RUN; no second strobe while held.
- In RUN, `btn_start` bouncing high 2 cycles / low 1 cycle ×3, then stable high → single START suppressed (ignored in RUN, no `valid`); with `CMD_TOGGLE_EN` → one PAUSE strobe, `state`=PAUSED.
- In RUN, `btn_pause` and `btn_stop` rise on the same edge → one strobe `opcode`=3'b100, `state`=IDLE, no PAUSE.
- PAUSED, press start → START, `state`=RUN; press pause in IDLE → no `valid`; press stop in IDLE → STOP strobe, stays IDLE.
- `btn_start` held, `rst` pulsed low for 1 cycle at debounce count 3 → outputs cleared; START strobe exactly DEBOUNCE_CYCLES+3 edges after reset release.
